// File: rtl/tcm_lsu_master.sv
// tcm_lsu_master: sized, byte-addressed load/store initiator driving a word-organised, byte-masked TCM port
module tcm_lsu_master #(
    parameter int DP = 512,
    parameter int DW = 32,
    parameter int MW = 4,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_din_o,
    output logic          ram_we_o,
    output logic [MW-1:0] ram_wem_o,
    input  logic [DW-1:0] ram_dout_i
);
    typedef enum logic [1:0] {IDLE, RD, RSP} state_t;
    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    lane_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;
    logic [31:0]   rsp_rdata_d;
    logic          idle;
    logic          err;
    logic          st;
    logic [MW-1:0] wem;
    logic [31:0]   bsel;
    logic [7:0]    b;
    logic [15:0]   h;
    // decode the incoming request into error, lane mask, replicated data and the RD-cycle load result
    always_comb begin
        idle = state_q == IDLE;
        err = (req_size_i == 2'b11) | ((req_size_i == 2'b01) & req_addr_i[0]) |
              ((req_size_i == 2'b10) & (|req_addr_i[1:0])) | ({2'b00, req_addr_i[31:2]} >= 32'(DP));
        st = idle & rst_n & req_valid_i & req_we_i & ~err;
        wem = req_size_i == 2'b00 ? MW'(4'b0001) << req_addr_i[1:0] :
              req_size_i == 2'b01 ? MW'(4'b0011) << req_addr_i[1:0] : MW'(4'b1111);
        bsel = ram_dout_i >> {lane_q, 3'b000};
        b = bsel[7:0];
        h = lane_q[1] ? ram_dout_i[31:16] : ram_dout_i[15:0];
        rsp_rdata_d = size_q == 2'b00 ? {{24{~uns_q & b[7]}}, b} :
                      size_q == 2'b01 ? {{16{~uns_q & h[15]}}, h} : ram_dout_i;
    end
    assign req_ready_o = idle & rst_n;
    assign ram_we_o    = st;
    assign ram_wem_o   = st ? wem : '0;
    assign ram_addr_o  = idle ? AW'(req_addr_i[31:2]) : addr_q;
    assign ram_din_o   = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} :
                         req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    // request/response FSM: latch on accept, capture load data in RD, hold the response until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            lane_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    addr_q      <= AW'(req_addr_i[31:2]);
                    size_q      <= req_size_i;
                    uns_q       <= req_unsigned_i;
                    lane_q      <= req_addr_i[1:0];
                    rsp_err_q   <= err;
                    rsp_rdata_q <= '0;
                    state_q     <= (req_we_i | err) ? RSP : RD;
                    rsp_valid_q <= req_we_i | err;
                end
                RD: begin
                    rsp_rdata_q <= rsp_rdata_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RSP;
                end
                RSP: if (rsp_ready_i) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
